// File: rtl/des_expand_mix.sv
// DES round front end: E-expansion of the right half-block XORed with the round subkey,
// registered behind a two-entry (output + skid) elastic buffer, with a wrapping round tag.
module des_expand_mix #(
   parameter int ROUNDS = 16
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Start,
   input  logic [31:0] RIn,
   input  logic [47:0] KeyIn,
   input  logic        InValid,
   output logic        InReady,
   output logic [47:0] MixOut,
   output logic [3:0]  RoundOut,
   output logic        LastRound,
   output logic        OutValid,
   input  logic        OutReady
);

   localparam logic [3:0] LastTag = 4'(ROUNDS - 1);

   logic [47:0] expanded;
   logic [47:0] mixNew;

   logic        outValidReg,  outValidNext;
   logic [47:0] outMixReg,    outMixNext;
   logic [3:0]  outRoundReg,  outRoundNext;
   logic        outLastReg,   outLastNext;
   logic        skidValidReg, skidValidNext;
   logic [47:0] skidMixReg,   skidMixNext;
   logic [3:0]  skidRoundReg, skidRoundNext;
   logic        skidLastReg,  skidLastNext;
   logic        inReadyReg,   inReadyNext;
   logic [3:0]  roundCntReg,  roundCntNext;

   logic        accept;
   logic        drain;
   logic [3:0]  tagNow;
   logic        tagIsLast;

   // Group g takes DES bits 4g..4g+5 MSB first; bit 0 wraps to 32 and bit 33 wraps to 1.
   // DES bit b lives at RIn[32-b].
   for (genvar gi = 0; gi < 8; gi++) begin : gGroup
      for (genvar gk = 0; gk < 6; gk++) begin : gBit
         localparam int DesIdx = 4 * gi + gk;
         localparam int DesBit = (DesIdx == 0) ? 32 : ((DesIdx == 33) ? 1 : DesIdx);
         assign expanded[47 - 6 * gi - gk] = RIn[32 - DesBit];
      end
   end

   assign mixNew    = expanded ^ KeyIn;
   assign accept    = InValid && inReadyReg;
   assign drain     = outValidReg && OutReady;
   assign tagNow    = Start ? 4'd0 : roundCntReg;
   assign tagIsLast = (tagNow == LastTag);

   always_comb begin
      outValidNext  = outValidReg;
      outMixNext    = outMixReg;
      outRoundNext  = outRoundReg;
      outLastNext   = outLastReg;
      skidValidNext = skidValidReg;
      skidMixNext   = skidMixReg;
      skidRoundNext = skidRoundReg;
      skidLastNext  = skidLastReg;
      roundCntNext  = tagNow;

      if (accept) begin
         roundCntNext = tagIsLast ? 4'd0 : tagNow + 4'd1;
      end

      if (!outValidReg || drain) begin
         // Output slot frees up: skid item has priority so order stays FIFO.
         if (skidValidReg) begin
            outValidNext  = 1'b1;
            outMixNext    = skidMixReg;
            outRoundNext  = skidRoundReg;
            outLastNext   = skidLastReg;
            skidValidNext = 1'b0;
         end else if (accept) begin
            outValidNext = 1'b1;
            outMixNext   = mixNew;
            outRoundNext = tagNow;
            outLastNext  = tagIsLast;
         end else begin
            outValidNext = 1'b0;
         end
      end else if (accept) begin
         skidValidNext = 1'b1;
         skidMixNext   = mixNew;
         skidRoundNext = tagNow;
         skidLastNext  = tagIsLast;
      end

      // Ready comes from a flop so upstream never sees a path from OutReady.
      inReadyNext = !skidValidNext;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         outValidReg  <= 1'b0;
         outMixReg    <= '0;
         outRoundReg  <= '0;
         outLastReg   <= 1'b0;
         skidValidReg <= 1'b0;
         skidMixReg   <= '0;
         skidRoundReg <= '0;
         skidLastReg  <= 1'b0;
         inReadyReg   <= 1'b0;
         roundCntReg  <= '0;
      end else begin
         outValidReg  <= outValidNext;
         outMixReg    <= outMixNext;
         outRoundReg  <= outRoundNext;
         outLastReg   <= outLastNext;
         skidValidReg <= skidValidNext;
         skidMixReg   <= skidMixNext;
         skidRoundReg <= skidRoundNext;
         skidLastReg  <= skidLastNext;
         inReadyReg   <= inReadyNext;
         roundCntReg  <= roundCntNext;
      end
   end

   assign InReady   = inReadyReg;
   assign MixOut    = outMixReg;
   assign RoundOut  = outRoundReg;
   assign LastRound = outLastReg;
   assign OutValid  = outValidReg;

endmodule

// File: tb/tb_des_expand_mix.sv
// Directed bench for des_expand_mix: expansion vectors from a table, then hand-written
// sequences for back-pressure, tag wrap, Start and asynchronous reset.
module tb_des_expand_mix;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Start;
   logic [31:0] RIn;
   logic [47:0] KeyIn;
   logic        InValid;
   logic        InReady;
   logic [47:0] MixOut;
   logic [3:0]  RoundOut;
   logic        LastRound;
   logic        OutValid;
   logic        OutReady;

   int compared = 0;
   int mismatched = 0;

   des_expand_mix #(.ROUNDS(16)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .RIn(RIn), .KeyIn(KeyIn),
      .InValid(InValid), .InReady(InReady), .MixOut(MixOut), .RoundOut(RoundOut),
      .LastRound(LastRound), .OutValid(OutValid), .OutReady(OutReady)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] rIn;
      logic [47:0] keyIn;
      logic [47:0] expMix;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{32'h00000000, 48'h000000000000, 48'h000000000000};
      vecs[1] = '{32'h00000001, 48'h000000000000, 48'h800000000002};
      vecs[2] = '{32'h80000000, 48'h000000000000, 48'h400000000001};
      vecs[3] = '{32'h00000000, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
      vecs[4] = '{32'hF0F0F0F0, 48'h000000000000, 48'h7A17A17A17A1};
      vecs[5] = '{32'hF0F0F0F0, 48'h7A17A17A17A1, 48'h000000000000};
      vecs[6] = '{32'hFFFFFFFF, 48'h123456789ABC, 48'hEDCBA9876543};
      vecs[7] = '{32'h00000000, 48'h123456789ABC, 48'h123456789ABC};

      Rst_n = 1'b0; Start = 1'b0; RIn = '0; KeyIn = '0; InValid = 1'b0; OutReady = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_outvalid", 64'(OutValid), 64'd0);
      check("rst_inready", 64'(InReady), 64'd0);
      check("rst_mixout", 64'(MixOut), 64'd0);
      check("rst_roundout", 64'(RoundOut), 64'd0);
      check("rst_lastround", 64'(LastRound), 64'd0);
      #3 Rst_n = 1'b1;
      #1 check("rel_inready_before_edge", 64'(InReady), 64'd0);
      tick();
      check("rel_inready_after_edge", 64'(InReady), 64'd1);

      // Expansion table, one item per vector, tags 0..7
      OutReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RIn = vecs[i].rIn; KeyIn = vecs[i].keyIn; InValid = 1'b1;
         tick();
         InValid = 1'b0;
         check($sformatf("vec%0d_mix", i), 64'(MixOut), 64'(vecs[i].expMix));
         check($sformatf("vec%0d_tag", i), 64'(RoundOut), 64'(i));
         check($sformatf("vec%0d_valid", i), 64'(OutValid), 64'd1);
         check($sformatf("vec%0d_last", i), 64'(LastRound), 64'd0);
         if (i == 3) check("vec3_s2_group", 64'(MixOut[41:36]), 64'h3F);
      end
      tick();
      check("drain_empty", 64'(OutValid), 64'd0);

      // Back-pressure: three offers with output stalled
      Start = 1'b1; tick(); Start = 1'b0;
      OutReady = 1'b0; RIn = '0;
      InValid = 1'b1; KeyIn = 48'hA; tick();
      check("bp_a_out", 64'(MixOut), 64'hA);
      check("bp_ready_1", 64'(InReady), 64'd1);
      KeyIn = 48'hB; tick();
      check("bp_ready_low", 64'(InReady), 64'd0);
      check("bp_hold_a", 64'(MixOut), 64'hA);
      KeyIn = 48'hC; tick();
      check("bp_c_refused", 64'(InReady), 64'd0);
      check("bp_hold_a2", 64'(MixOut), 64'hA);
      check("bp_hold_tag", 64'(RoundOut), 64'd0);
      OutReady = 1'b1; tick();
      check("bp_b_out", 64'(MixOut), 64'hB);
      check("bp_b_tag", 64'(RoundOut), 64'd1);
      check("bp_ready_back", 64'(InReady), 64'd1);
      tick();
      InValid = 1'b0;
      check("bp_c_out", 64'(MixOut), 64'hC);
      check("bp_c_tag", 64'(RoundOut), 64'd2);
      tick();
      check("bp_empty", 64'(OutValid), 64'd0);

      // Tag wrap over 17 back-to-back items
      Start = 1'b1; tick(); Start = 1'b0;
      InValid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         KeyIn = 48'(i + 100);
         tick();
         check($sformatf("wrap%0d_tag", i), 64'(RoundOut), 64'(i % 16));
         check($sformatf("wrap%0d_last", i), 64'(LastRound), 64'((i % 16) == 15));
         check($sformatf("wrap%0d_mix", i), 64'(MixOut), 64'(i + 100));
      end
      InValid = 1'b0; tick();

      // Start coincident with the fifth accept
      Start = 1'b1; tick(); Start = 1'b0;
      InValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         KeyIn = 48'(i + 200);
         Start = (i == 4);
         tick();
         check($sformatf("start%0d_tag", i), 64'(RoundOut), 64'(i % 4));
      end
      Start = 1'b0; InValid = 1'b0; tick();

      // Start while two items are stored leaves their tags alone
      OutReady = 1'b0; InValid = 1'b1;
      KeyIn = 48'h111; tick();
      KeyIn = 48'h222; tick();
      InValid = 1'b0; Start = 1'b1; tick(); Start = 1'b0;
      check("keep_tag_out", 64'(RoundOut), 64'd4);
      check("keep_mix_out", 64'(MixOut), 64'h111);
      OutReady = 1'b1; tick();
      check("keep_tag_skid", 64'(RoundOut), 64'd5);
      check("keep_mix_skid", 64'(MixOut), 64'h222);
      OutReady = 1'b0; InValid = 1'b1; KeyIn = 48'h333; tick();
      InValid = 1'b0;
      check("full_again", 64'(InReady), 64'd0);

      // Asynchronous reset with two items stored
      #3 Rst_n = 1'b0;
      #1 check("arst_outvalid", 64'(OutValid), 64'd0);
      check("arst_inready", 64'(InReady), 64'd0);
      check("arst_mix", 64'(MixOut), 64'd0);
      #2 Rst_n = 1'b1;
      #1 check("arst_rel_inready", 64'(InReady), 64'd0);
      tick();
      check("arst_edge_inready", 64'(InReady), 64'd1);
      check("arst_no_stale", 64'(OutValid), 64'd0);
      OutReady = 1'b1; InValid = 1'b1; KeyIn = 48'h444; tick();
      InValid = 1'b0;
      check("arst_first_tag", 64'(RoundOut), 64'd0);
      check("arst_first_mix", 64'(MixOut), 64'h444);
      check("arst_first_valid", 64'(OutValid), 64'd1);
      tick();
      check("arst_drained", 64'(OutValid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
